left_key_mode_seq: RTL

- Sequencer for the four left-column mode keys on the Launchpad board.
- Synchronises and debounces LEFT_KEY[3:0], then selects the active mode with priority.
- Runs the record-arm state machine: long-press to arm, then a release delay before recording starts.
- Generates the shared blink phase; the LED pattern driver consumes its outputs.

---
 rtl/left_key_mode_seq_if.sv | 37 +++
 rtl/left_key_mode_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/left_key_mode_seq_if.sv
// ----------------------------------------------------------------------------
// left_key_mode_seq_if
// Bundles the key inputs and the sequencer outputs of left_key_mode_seq.
//   LEFT_KEY    [3:0] raw key levels from the board, 1 = pressed, asynchronous
//   KEY_EVT     [3:0] one-cycle debounced press pulse per key
//   MODE        [1:0] active mode index 0..3
//   MODE_VALID        a mode has been selected since reset
//   REC_STATE   [2:0] record FSM state (IDLE=0 HOLD=1 ARMED=2 WAIT=3 RUN=4)
//   REC_START         one-cycle pulse on entry to RUN
//   REC_DONE          one-cycle pulse on exit from RUN
//   REC_TIMEOUT       one-cycle pulse on recording auto-stop
//   BLINK             shared blink phase for the LED pattern driver
// master: the key source (board / bench). slave: the sequencer.
// ----------------------------------------------------------------------------
interface left_key_mode_seq_if;
    logic [3:0] LEFT_KEY;
    logic [3:0] KEY_EVT;
    logic [1:0] MODE;
    logic       MODE_VALID;
    logic [2:0] REC_STATE;
    logic       REC_START;
    logic       REC_DONE;
    logic       REC_TIMEOUT;
    logic       BLINK;

    modport master (
        output LEFT_KEY,
        input  KEY_EVT, MODE, MODE_VALID, REC_STATE,
        input  REC_START, REC_DONE, REC_TIMEOUT, BLINK
    );

    modport slave (
        input  LEFT_KEY,
        output KEY_EVT, MODE, MODE_VALID, REC_STATE,
        output REC_START, REC_DONE, REC_TIMEOUT, BLINK
    );
endinterface

// File: rtl/left_key_mode_seq.sv
// ----------------------------------------------------------------------------
// left_key_mode_seq
// Sequencer for the four left-column mode keys: synchronises and debounces
// the keys, selects the active mode (lowest pressed index wins), runs the
// record-arm FSM (long-press arms, release delay starts recording) and
// generates the free-running blink phase.
// Ports:
//   CLK    system clock
//   RESET  synchronous reset, active low
//   bus    left_key_mode_seq_if.slave (keys in, events/mode/record/blink out)
// Optional feature: define REC_TIMEOUT_EN to auto-stop recording after
// MAX_REC_CYCLES cycles in RUN; otherwise REC_TIMEOUT is tied low.
// ----------------------------------------------------------------------------
module left_key_mode_seq #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int HOLD_CYCLES     = 72000000,
    parameter int WAIT_CYCLES     = 72000000,
    parameter int BLINK_HALF      = 12000000,
    parameter int MAX_REC_CYCLES  = 720000000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    left_key_mode_seq_if.slave    bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HO_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int WT_W = (WAIT_CYCLES > 1)     ? $clog2(WAIT_CYCLES)     : 1;
    localparam int BL_W = (BLINK_HALF > 1)      ? $clog2(BLINK_HALF)      : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLD_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(WAIT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || WAIT_CYCLES < 2 ||
        BLINK_HALF < 2 || MAX_REC_CYCLES < 2) begin : g_param_check
        $error("left_key_mode_seq: cycle parameters must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_ARMED = 3'd2,
        S_WAIT  = 3'd3,
        S_RUN   = 3'd4
    } rec_state_t;

    // Lowest pressed index has priority when several events coincide.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    logic [3:0]      r_sync1, r_sync2;
    logic [3:0]      r_db, r_db_prev;
    logic [DB_W-1:0] r_db_cnt [4];
    logic [3:0]      r_key_evt;
    logic [1:0]      r_mode;
    logic            r_mode_valid;
    rec_state_t      r_state, w_state_nxt;
    logic [HO_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [WT_W-1:0] r_wait_cnt, w_wait_nxt;
    logic            r_rec_start, r_rec_done;
    logic            w_start, w_done, w_mode_chg, w_fsm_en;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink;

    // ---- synchroniser, debounce and press-event stage ----
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            r_key_evt <= '0;
            for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1   <= bus.LEFT_KEY;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            // Press event follows the debounced rising edge by one register.
            r_key_evt <= r_db & ~r_db_prev;
            for (int k = 0; k < 4; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_db[k]     <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // ---- mode select stage ----
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_mode       <= 2'd0;
            r_mode_valid <= 1'b0;
        end else if (|r_key_evt) begin
            r_mode       <= lowest_idx(r_key_evt);
            r_mode_valid <= 1'b1;
        end
    end

    // Any press other than key2 changes mode away from recording.
    assign w_mode_chg = r_key_evt[0] | r_key_evt[1] | r_key_evt[3];
    assign w_fsm_en   = r_mode_valid && (r_mode == 2'd2);

`ifdef REC_TIMEOUT_EN
    localparam int RN_W = (MAX_REC_CYCLES > 1) ? $clog2(MAX_REC_CYCLES) : 1;
    localparam logic [RN_W-1:0] RN_LAST = RN_W'(MAX_REC_CYCLES - 1);
    logic [RN_W-1:0] r_run_cnt, w_run_nxt;
    logic            r_rec_timeout, w_timeout;
`endif

    // ---- record FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_wait_nxt  = r_wait_cnt;
`ifdef REC_TIMEOUT_EN
        w_run_nxt   = r_run_cnt;
        w_timeout   = 1'b0;
`endif
        if (w_mode_chg) begin
            // Mode change overrides every FSM transition in the same cycle.
            w_state_nxt = S_IDLE;
            w_hold_nxt  = '0;
            w_wait_nxt  = '0;
`ifdef REC_TIMEOUT_EN
            w_run_nxt   = '0;
`endif
        end else if (w_fsm_en) begin
            case (r_state)
                S_IDLE: begin
                    if (r_db[2]) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = '0;
                    end
                end
                S_HOLD: begin
                    if (!r_db[2])                 w_state_nxt = S_IDLE;
                    else if (r_hold_cnt == HO_LAST) w_state_nxt = S_ARMED;
                    else                          w_hold_nxt  = r_hold_cnt + 1'b1;
                end
                S_ARMED: begin
                    if (!r_db[2]) begin
                        w_state_nxt = S_WAIT;
                        w_wait_nxt  = '0;
                    end
                end
                S_WAIT: begin
                    if (r_db[2]) begin
                        w_state_nxt = S_ARMED;
                        w_wait_nxt  = '0;
                    end else if (r_wait_cnt == WT_LAST) begin
                        w_state_nxt = S_RUN;
`ifdef REC_TIMEOUT_EN
                        w_run_nxt   = '0;
`endif
                    end else begin
                        w_wait_nxt  = r_wait_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_key_evt[2]) begin
                        w_state_nxt = S_IDLE;
`ifdef REC_TIMEOUT_EN
                    end else if (r_run_cnt == RN_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_timeout   = 1'b1;
                    end else begin
                        w_run_nxt   = r_run_cnt + 1'b1;
`endif
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_start = (w_state_nxt == S_RUN) && (r_state != S_RUN);
        w_done  = (r_state == S_RUN) && (w_state_nxt != S_RUN);
    end

    // ---- record FSM: state register and registered pulses ----
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_rec_start <= 1'b0;
            r_rec_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_rec_start <= w_start;
            r_rec_done  <= w_done;
        end
    end

`ifdef REC_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_run_cnt     <= '0;
            r_rec_timeout <= 1'b0;
        end else begin
            r_run_cnt     <= w_run_nxt;
            r_rec_timeout <= w_timeout;
        end
    end
    assign bus.REC_TIMEOUT = r_rec_timeout;
`else
    assign bus.REC_TIMEOUT = 1'b0;
`endif

    // ---- blink phase stage ----
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BL_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign bus.KEY_EVT    = r_key_evt;
    assign bus.MODE       = r_mode;
    assign bus.MODE_VALID = r_mode_valid;
    assign bus.REC_STATE  = r_state;
    assign bus.REC_START  = r_rec_start;
    assign bus.REC_DONE   = r_rec_done;
    assign bus.BLINK      = r_blink;
endmodule
